// File: rtl/spi_burst_slave_if.sv
// spi_burst_slave_if: SPI pins and register-side bus of spi_burst_slave.
// SPI_MISO_OE_EN adds the spimiso_oe tristate enable.
interface spi_burst_slave_if #(parameter int ASZ = 7, parameter int DSZ = 32);
  logic spicsl, spimosi, spimiso, re, wtog;
  logic [ASZ-1:0] addr;
  logic [DSZ-1:0] rdat, wdat;
`ifdef SPI_MISO_OE_EN
  logic spimiso_oe;
  modport slave(input spicsl, spimosi, rdat, output spimiso, spimiso_oe, addr, re, wdat, wtog);
  modport master(output spicsl, spimosi, rdat, input spimiso, spimiso_oe, addr, re, wdat, wtog);
`else
  modport slave(input spicsl, spimosi, rdat, output spimiso, addr, re, wdat, wtog);
  modport master(output spicsl, spimosi, rdat, input spimiso, addr, re, wdat, wtog);
`endif
endinterface

// File: rtl/spi_burst_slave.sv
// spi_burst_slave: mode-0 SPI burst register slave with toggle write handshake.
// Define SPI_MISO_OE_EN to add spimiso_oe for an external tristate buffer.
module spi_burst_slave #(
  parameter int ASZ = 7,
  parameter int DSZ = 32,
  parameter bit AUTO_INC = 1
) (
  input logic spiclk,
  input logic spi_reset,
  spi_burst_slave_if.slave bus
);
  typedef enum logic {HDR, DATA} phase_t;
  localparam int CW = $clog2(DSZ > ASZ + 1 ? DSZ : ASZ + 1);
  phase_t phase;
  logic [CW-1:0] cnt;
  logic [ASZ-2:0] a_sr;
  logic [ASZ-1:0] a_nxt, base, k, off, off_n, addr_q;
  logic [DSZ-2:0] d_sr;
  logic [DSZ-1:0] d_nxt, sh, wdat_q;
  logic rd, re_q, wtog_q, fclr, hdr_end, word_end, mo_en;
  assign fclr = spi_reset || bus.spicsl;
  assign a_nxt = {a_sr, bus.spimosi};
  assign d_nxt = {d_sr, bus.spimosi};
  assign hdr_end = phase == HDR && cnt == CW'(ASZ);
  assign word_end = phase == DATA && cnt == CW'(DSZ - 1);
  assign off = AUTO_INC ? k : '0;
  assign off_n = AUTO_INC ? k + 1'b1 : '0;
  // Frame state: cleared by chip select as well as power-on reset
  always_ff @(posedge spiclk or posedge fclr)
    if (fclr) begin
      phase <= HDR;
      cnt <= '0;
      re_q <= 1'b0;
      a_sr <= '0;
      d_sr <= '0;
      base <= '0;
      k <= '0;
    end else begin
      re_q <= rd && (hdr_end || word_end);
      cnt <= (hdr_end || word_end) ? '0 : cnt + 1'b1;
      if (phase == HDR) begin
        a_sr <= a_nxt[ASZ-2:0];
        if (hdr_end) begin
          phase <= DATA;
          base <= a_nxt;
          k <= '0;
        end
      end else begin
        d_sr <= d_nxt[DSZ-2:0];
        if (word_end) k <= k + 1'b1;
      end
    end
  // Handshake outputs survive chip select so the system side can sample them late
  always_ff @(posedge spiclk or posedge spi_reset)
    if (spi_reset) begin
      rd <= 1'b0;
      addr_q <= '0;
      wdat_q <= '0;
      wtog_q <= 1'b0;
    end else if (!bus.spicsl) begin
      if (phase == HDR && cnt == '0) rd <= bus.spimosi;
      if (hdr_end) addr_q <= a_nxt;
      else if (word_end) addr_q <= base + (rd ? off_n : off);
      if (word_end && !rd) begin
        wdat_q <= d_nxt;
        wtog_q <= ~wtog_q;
      end
    end
  always_ff @(negedge spiclk or posedge fclr)
    if (fclr) sh <= '0;
    else sh <= re_q ? bus.rdat : {sh[DSZ-2:0], 1'b0};
  assign mo_en = phase == DATA && rd;
  assign bus.addr = addr_q;
  assign bus.re = re_q;
  assign bus.wdat = wdat_q;
  assign bus.wtog = wtog_q;
`ifdef SPI_MISO_OE_EN
  assign bus.spimiso_oe = mo_en && !bus.spicsl;
  assign bus.spimiso = mo_en && sh[DSZ-1];
`else
  assign bus.spimiso = mo_en && sh[DSZ-1];
`endif
endmodule

// File: tb/tb_spi_burst_slave.sv
// tb_spi_burst_slave: random and directed SPI frames against AUTO_INC=1 and AUTO_INC=0 slaves.
module tb_spi_burst_slave;
  localparam int ASZ = 7, DSZ = 32;
  logic spiclk = 1'b0, spi_reset = 1'b1, cs = 1'b1, mosi = 1'b0;
  spi_burst_slave_if #(.ASZ(ASZ), .DSZ(DSZ)) b0 ();
  spi_burst_slave_if #(.ASZ(ASZ), .DSZ(DSZ)) b1 ();
  spi_burst_slave #(.ASZ(ASZ), .DSZ(DSZ), .AUTO_INC(1)) u0 (.spiclk(spiclk), .spi_reset(spi_reset), .bus(b0));
  spi_burst_slave #(.ASZ(ASZ), .DSZ(DSZ), .AUTO_INC(0)) u1 (.spiclk(spiclk), .spi_reset(spi_reset), .bus(b1));
  logic [DSZ-1:0] mem [128];
  logic [DSZ-1:0] wq [4];
  logic [ASZ-1:0] m_addr [2];
  logic [DSZ-1:0] m_wdat [2];
  logic m_wtog [2];
  int checks = 0, errors = 0;
  assign b0.spicsl = cs;
  assign b1.spicsl = cs;
  assign b0.spimosi = mosi;
  assign b1.spimosi = mosi;
  assign b0.rdat = mem[b0.addr];
  assign b1.rdat = mem[b1.addr];

  task automatic chk(input string tag, input logic [DSZ-1:0] got, input logic [DSZ-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic re_e, input logic [1:0] mo_e);
    chk({tag, "/re0"}, b0.re, re_e);
    chk({tag, "/re1"}, b1.re, re_e);
    chk({tag, "/addr0"}, b0.addr, m_addr[0]);
    chk({tag, "/addr1"}, b1.addr, m_addr[1]);
    chk({tag, "/wdat0"}, b0.wdat, m_wdat[0]);
    chk({tag, "/wdat1"}, b1.wdat, m_wdat[1]);
    chk({tag, "/wtog0"}, b0.wtog, m_wtog[0]);
    chk({tag, "/wtog1"}, b1.wtog, m_wtog[1]);
    chk({tag, "/miso0"}, b0.spimiso, mo_e[0]);
    chk({tag, "/miso1"}, b1.spimiso, mo_e[1]);
  endtask

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_addr[n] = '0;
      m_wdat[n] = '0;
      m_wtog[n] = 1'b0;
    end
  endtask

  // nbits > 0 cuts the frame short; rst_at >= 0 fires spi_reset after that bit
  task automatic frame(input logic rd, input logic [ASZ-1:0] base, input int nw, input int nbits, input int rst_at);
    int tot;
    logic re_e;
    logic [1:0] mo_e;
    tot = nbits > 0 ? nbits : 1 + ASZ + nw * DSZ;
    cs = 1'b0;
    #10;
    for (int i = 0; i < tot; i++) begin
      int j, w, bb;
      logic [ASZ-1:0] ea;
      j = i - ASZ - 1;
      w = j < 0 ? 0 : j / DSZ;
      bb = j < 0 ? 0 : j % DSZ;
      if (i == 0) mosi = rd;
      else if (i <= ASZ) mosi = base[ASZ-i];
      else if (rd) mosi = 1'($urandom);
      else mosi = wq[w][DSZ-1-bb];
      #10 spiclk = 1'b1;
      #5;
      re_e = rd && (i == ASZ || (i > ASZ && bb == DSZ - 1));
      for (int n = 0; n < 2; n++) begin
        ea = base + ASZ'(n == 0 ? w : 0);
        mo_e[n] = (i > ASZ && rd) ? mem[ea][DSZ-1-bb] : 1'b0;
        if (i == ASZ) m_addr[n] = base;
        if (i > ASZ && bb == DSZ - 1) begin
          if (rd) m_addr[n] = base + ASZ'(n == 0 ? w + 1 : 0);
          else begin
            m_addr[n] = ea;
            m_wdat[n] = wq[w];
            m_wtog[n] = ~m_wtog[n];
          end
        end
      end
      chk_all($sformatf("bit%0d", i), re_e, mo_e);
      if (i == rst_at) begin
        spi_reset = 1'b1;
        #1;
        model_reset();
        chk_all("midrst", 1'b0, 2'b00);
        spiclk = 1'b0;
        break;
      end
      #5 spiclk = 1'b0;
    end
    #5 cs = 1'b1;
    #1 chk_all("csh", 1'b0, 2'b00);
    #10 spi_reset = 1'b0;
    #10;
  endtask

  initial begin
    int nw, full, cut, ra;
    for (int a = 0; a < 128; a++) mem[a] = DSZ'(a);
    model_reset();
    #15 chk_all("reset", 1'b0, 2'b00);
    spi_reset = 1'b0;
    #10;
    wq[0] = 32'hDEADBEEF;
    frame(1'b0, 7'h05, 1, 0, -1);
    wq[0] = 32'h11111111; wq[1] = 32'h22222222; wq[2] = 32'h33333333;
    frame(1'b0, 7'h7E, 3, 0, -1);
    frame(1'b1, 7'h03, 2, 0, -1);
    frame(1'b1, 7'h10, 3, 0, -1);
    wq[0] = $urandom;
    frame(1'b0, 7'h20, 1, 1 + ASZ + 20, -1);
    frame(1'b0, 7'h21, 1, 0, -1);
    frame(1'b1, 7'h55, 0, 0, -1);
    frame(1'b0, 7'h66, 0, 4, -1);
    frame(1'b1, 7'h30, 3, 0, 1 + ASZ + 40);
    wq[0] = $urandom;
    frame(1'b0, 7'h09, 1, 0, -1);
    for (int a = 0; a < 128; a++) mem[a] = $urandom;
    for (int t = 0; t < 40; t++) begin
      for (int q = 0; q < 4; q++) wq[q] = $urandom;
      nw = $urandom_range(0, 3);
      full = 1 + ASZ + nw * DSZ;
      cut = ($urandom % 4 == 0) ? $urandom_range(1, full) : 0;
      ra = ($urandom % 8 == 0) ? $urandom_range(0, full - 1) : -1;
      frame(1'($urandom), ASZ'($urandom), nw, cut, ra);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
